rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 125 ++++++++++++
 tb/tb_rr_arbiter4.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-requester round-robin arbiter; one owner at a time, released by done or request drop.
// Define ARB_TIMEOUT_EN to add a hold counter that revokes a grant after HOLD_MAX cycles.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [1:0] id_nxt;
  logic       release_now;
  logic       limit;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arbiter4: HOLD_MAX must be in 2..255");
  end

  // First set request bit scanning from p upward with 2-bit wrap.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign release_now = (state == GRANT) && (done || !req[gnt_id]);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       tmo;

  // A normal release on the limit edge wins, so the limit only fires without one.
  assign limit = (state == GRANT) && !release_now && (cnt == HOLD_LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE) begin
      cnt_nxt = 8'd0;
    end else if (!release_now && !limit) begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
      tmo <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      tmo <= limit;
    end
  end

  assign timeout = tmo;
`else
  assign limit   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    id_nxt    = gnt_id;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nxt = GRANT;
          id_nxt    = pick(req, ptr);
        end
      end
      GRANT: begin
        if (release_now || limit) begin
          state_nxt = IDLE;
          id_nxt    = 2'd0;
          ptr_nxt   = gnt_id + 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        id_nxt    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt_id <= 2'd0;
      ptr    <= 2'd0;
    end else begin
      state  <= state_nxt;
      gnt_id <= id_nxt;
      ptr    <= ptr_nxt;
    end
  end

  assign busy = (state == GRANT);
  assign gnt  = busy ? (4'b0001 << gnt_id) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with an owner/pointer reference model checked every cycle.
module tb_rr_arbiter4;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  rr_arbiter4 #(.HOLD_MAX(HM)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference: current owner (-1 when none), rotation start, cycles held so far.
  int   m_own = -1;
  int   m_ptr = 0;
  int   m_hold = 0;
  logic m_tmo = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int   o;
    int   p;
    int   h;
    logic t;
    if (!rst_n) begin
      m_own  <= -1;
      m_ptr  <= 0;
      m_hold <= 0;
      m_tmo  <= 1'b0;
    end else begin
      o = m_own;
      p = m_ptr;
      h = m_hold;
      t = 1'b0;
      if (o < 0) begin
        for (int k = 0; k < 4; k++) begin
          if (o < 0 && req[(m_ptr + k) % 4]) begin
            o = (m_ptr + k) % 4;
            h = 1;
          end
        end
      end else if (done || !req[o]) begin
        p = (o + 1) % 4;
        o = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (h == HM) begin
        p = (o + 1) % 4;
        o = -1;
        t = 1'b1;
      end
`endif
      else begin
        h = h + 1;
      end
      m_own  <= o;
      m_ptr  <= p;
      m_hold <= h;
      m_tmo  <= t;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_gnt", 32'(gnt), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("model_gnt_id", 32'(gnt_id), (m_own < 0) ? 32'd0 : 32'(m_own));
    chk("model_busy", 32'(busy), (m_own < 0) ? 32'd0 : 32'd1);
    chk("model_timeout", 32'(timeout), 32'(m_tmo));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int budget);
    int n;
    n = 0;
    while (!busy && n < budget) begin
      step();
      n++;
    end
    chk("wait_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq[0] = 4'b0001;
    rr_seq[1] = 4'b0010;
    rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000;
    rr_seq[4] = 4'b0001;

    repeat (3) step();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_gnt_id", 32'(gnt_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);

    // Full rotation with all four requesting.
    req = 4'b1111;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_busy(4);
      chk("rr_gnt", 32'(gnt), 32'(rr_seq[i]));
      done = 1'b1;
      step();
      done = 1'b0;
      chk("rr_idle_gap", 32'(busy), 32'd0);
    end

    // Pointer at 2 after requester 1; 0011 wraps to requester 0.
    req = 4'b0010;
    step();
    chk("ptr2_first_id", 32'(gnt_id), 32'd1);
    done = 1'b1;
    req = 4'b0011;
    step();
    done = 1'b0;
    chk("ptr2_release", 32'(busy), 32'd0);
    step();
    chk("ptr2_wrap_gnt", 32'(gnt), 32'b0001);
    chk("ptr2_wrap_id", 32'(gnt_id), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    req = 4'b0000;

    // Request drop releases requester 2, pointer moves to 3.
    req = 4'b0100;
    step();
    chk("drop_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    step();
    chk("drop_gnt_clr", 32'(gnt), 32'd0);
    chk("drop_busy_clr", 32'(busy), 32'd0);
    req = 4'b1111;
    step();
    chk("drop_ptr3", 32'(gnt), 32'b1000);
    req = 4'b0000;
    step();

    // A request raised and dropped during someone else's grant is lost.
    req = 4'b0001;
    step();
    req = 4'b0011;
    step();
    chk("hold_owner", 32'(gnt), 32'b0001);
    req = 4'b0001;
    done = 1'b1;
    step();
    req = 4'b0000;
    done = 1'b0;
    step();
    chk("lost_req", 32'(busy), 32'd0);

    // Asynchronous reset mid-grant.
    req = 4'b0010;
    step();
    chk("pre_reset_gnt", 32'(gnt), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    req = 4'b1000;
    step();
    chk("post_reset_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    step();

    // Pointer restarts at 0 after reset: grant 1 then reset, 1111 goes to 0.
    req = 4'b0010;
    step();
    #2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    step();
    chk("reset_ptr0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step();

`ifdef ARB_TIMEOUT_EN
    req = 4'b0001;
    step();
    chk("tmo_cycle1", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_hold", 32'(gnt), 32'b0001);
    end
    step();
    chk("tmo_revoke", 32'(busy), 32'd0);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    step();
    chk("tmo_regrant", 32'(gnt), 32'b0001);
    chk("tmo_pulse_end", 32'(timeout), 32'd0);
    repeat (3) step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("limit_release_busy", 32'(busy), 32'd0);
    chk("limit_release_tmo", 32'(timeout), 32'd0);
    req = 4'b0000;
    step();
`else
    req = 4'b0100;
    step();
    chk("long_first", 32'(gnt), 32'b0100);
    repeat (1000) step();
    chk("long_gnt", 32'(gnt), 32'b0100);
    chk("long_timeout", 32'(timeout), 32'd0);
    req = 4'b0000;
    step();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
